// File: rtl/vga_timing_gen.sv
// Parametrised VGA-style sync generator: hsync/vsync, active-video, pixel coordinates, line/frame strobes.
// Optional 16-bit frame counter output enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 128,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 9,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 28,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int H_W       = 10,
  parameter int V_W       = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           px_en,
  output logic           hsync,
  output logic           vsync,
  output logic           activevideo,
  output logic [H_W-1:0] x_px,
  output logic [V_W-1:0] y_px,
`ifdef VGA_TIMING_FRAME_COUNT_EN
  output logic [15:0]    frame_cnt,
`endif
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_ACT_END    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SYNC_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_SYNC_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0] H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT_END    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_SYNC_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0] V_LAST       = V_W'(V_TOTAL - 1);

  logic [H_W-1:0] hc_q, hc_d;
  logic [V_W-1:0] vc_q, vc_d;
  logic [H_W-1:0] x_px_q, x_px_d;
  logic [V_W-1:0] y_px_q, y_px_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           activevideo_q, activevideo_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;

  // Each px_en edge presents the decode of the pre-increment counters,
  // giving one pixel step of latency between counter and outputs.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    hc_d          = hc_q;
    vc_d          = vc_q;
    x_px_d        = x_px_q;
    y_px_d        = y_px_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    activevideo_d = activevideo_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (px_en) begin
      x_px_d        = hc_q;
      y_px_d        = vc_q;
      hsync_d       = (hc_q >= H_SYNC_START && hc_q < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (vc_q >= V_SYNC_START && vc_q < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
      activevideo_d = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
      line_start_d  = (hc_q == '0);
      frame_start_d = (hc_q == '0) && (vc_q == '0);
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      x_px_q        <= '0;
      y_px_q        <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      activevideo_q <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      x_px_q        <= x_px_d;
      y_px_q        <= y_px_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      activevideo_q <= activevideo_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign activevideo = activevideo_q;
  assign x_px        = x_px_q;
  assign y_px        = y_px_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Counts on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480@72Hz sync generator.
- Produces hsync, vsync, active-video, pixel coordinates and frame/line start strobes for any VGA-style mode.
- Timing, sync polarity and counter widths are parameters. A pixel-enable input lets it run from a fast system clock. Asynchronous reset is added.
- Sits between the clock/PLL block and the pixel renderers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 40, hsync pulse width (pixels)
- H_BP, 128, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 28, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync (0 = active low)
- H_W, 10, width of the horizontal counter and x_px; must hold H_TOTAL-1
- V_W, 10, width of the vertical counter and y_px; must hold V_TOTAL-1

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous reset, active low
- px_en  in  1  pixel enable; one pixel step per clk cycle with px_en=1
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- activevideo  out  1  high while the presented position is visible
- x_px  out  H_W  horizontal position of the presented pixel
- y_px  out  V_W  vertical position of the presented pixel
- line_start  out  1  one-clk pulse when the presented position has x=0
- frame_start  out  1  one-clk pulse when the presented position is (0,0)

Behaviour:
- Interface: single clock clk; reset_n is asynchronous, active low.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line order: active, front porch, sync, back porch. Active region is hc in [0,H_ACTIVE); sync region is hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vertical uses the same scheme on vc.
- Counters hc/vc reset to 0 and only advance on clk edges with px_en=1.
  - hc wraps at H_TOTAL-1 to 0.
  - vc increments when hc wraps, and itself wraps at V_TOTAL-1 to 0.
- Outputs are registered and updated only on px_en edges. Each update presents decode(hc,vc) of the pre-increment counter value. This gives one px_en of latency: the first px_en after reset presents (0,0).
- x_px/y_px equal the raw hc/vc in both active and blanking periods.
- activevideo = (hc<H_ACTIVE) && (vc<V_ACTIVE).
- hsync = HSYNC_POL in the h sync region, else ~HSYNC_POL. vsync is decoded from vc only, spans whole lines, and is aligned with hc=0 of each line.
- line_start / frame_start:
  - high for exactly one clk, on the px_en edge that presents hc=0 (respectively hc=0, vc=0);
  - low on every other cycle, including clk cycles with px_en=0.
- While px_en=0, all outputs except the strobes hold their values.
- Reset values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, activevideo=0, x_px=0, y_px=0, line_start=0, frame_start=0, hc=vc=0.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). After release, the next px_en presents (0,0) with both strobes high.
- Parameter legality: every porch/sync value >=1, H_TOTAL <= 2^H_W, V_TOTAL <= 2^V_W. Illegal sets are unsupported and are not checked in RTL.

Optional Feature:
- Macro VGA_TIMING_FRAME_COUNT_EN.
- Defined: adds output port frame_cnt, 16 bits, reset 0. It increments by 1 on each edge that raises frame_start (so it reads 1 after the first frame_start) and wraps 16'hFFFF -> 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults, px_en=1, release reset -> first edge: x=0, y=0, activevideo=1, line_start=1, frame_start=1. Edge 641: x=640, activevideo=0. Edges 665..704: hsync=0. Edge 833: x=0, y=1, line_start=1.
- Defaults, px_en toggling 1/0 -> hsync low for 80 clk. Strobes are exactly 1 clk wide. Outputs hold on px_en=0 cycles.
- Defaults, px_en=1, run 2 frames -> frame_start pulses 432640 px_en apart. vsync low for 2496 consecutive px_en, starting at y=489, x=0.
- Reset_n pulsed low asynchronously at x=300, y=100 -> outputs go to reset values before the next clk edge. First px_en after release presents (0,0).
- H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, VSYNC_POL=1 -> hsync high for x=10..12, 14-pixel lines. vsync high only on y=5. Frame is 98 px_en.
- VGA_TIMING_FRAME_COUNT_EN defined, small mode above -> frame_cnt=3 after the third frame_start. frame_cnt preloaded near the top wraps 16'hFFFF -> 0.
